// File: rtl/mipi_pkg.sv
// Shared CSI-2 definitions: data-type codes, parser states and header field helpers.
package mipi_pkg;

   localparam logic [5:0] DT_FS        = 6'h00;
   localparam logic [5:0] DT_FE        = 6'h01;
   localparam logic [5:0] DT_LS        = 6'h02;
   localparam logic [5:0] DT_LE        = 6'h03;
   localparam logic [5:0] DT_EMBED     = 6'h12;
   localparam logic [5:0] DT_RAW8      = 6'h2A;
   localparam logic [5:0] DT_RAW10     = 6'h2B;
   localparam logic [5:0] DT_LONG_MIN  = 6'h10;

   localparam int HDR_BYTES = 4;
   localparam int CRC_BYTES = 2;

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_SKIP    = 2'd2,
      ST_CRC     = 2'd3
   } parse_state_t;

   function automatic logic [5:0] di_dt(input logic [7:0] di);
      return di[5:0];
   endfunction

   function automatic logic [1:0] di_vc(input logic [7:0] di);
      return di[7:6];
   endfunction

   function automatic logic is_short_dt(input logic [5:0] dt);
      return dt < DT_LONG_MIN;
   endfunction

endpackage

// File: rtl/mipi_byte_packer.sv
// Packs accepted payload bytes into OUT_BYTES-wide words behind a single
// stall-holding output register; first byte of a word lands in [7:0].
module mipi_byte_packer #(
   parameter int OUT_BYTES = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   input  logic                   in_user,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic                   word_load,
   output logic [8*OUT_BYTES-1:0] m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tuser,
   output logic                   m_tlast
);

   localparam int CNT_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BYTES - 1);

   logic [CNT_W-1:0]       pack_cnt_reg;
   logic [8*OUT_BYTES-1:0] word_next;
   logic [8*OUT_BYTES-1:0] tdata_reg;
   logic                   tvalid_reg;
   logic                   tuser_reg;
   logic                   tlast_reg;
   logic                   in_fire;

   assign in_ready  = !tvalid_reg || m_tready;
   assign in_fire   = in_valid && in_ready;
   assign word_load = in_fire && (pack_cnt_reg == CNT_LAST);

   // The completing byte bypasses its lane so the word loads on the same edge.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_BYTES; gi++) begin : g_lane
         logic [7:0] lane_reg;

         assign word_next[8*gi +: 8] = (pack_cnt_reg == CNT_W'(gi)) ? in_data : lane_reg;

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               lane_reg <= '0;
            end else if (in_fire && (pack_cnt_reg == CNT_W'(gi))) begin
               lane_reg <= in_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pack_cnt_reg <= '0;
         tdata_reg    <= '0;
         tvalid_reg   <= 1'b0;
         tuser_reg    <= 1'b0;
         tlast_reg    <= 1'b0;
      end else begin
         if (in_fire) begin
            pack_cnt_reg <= (pack_cnt_reg == CNT_LAST) ? '0 : pack_cnt_reg + CNT_W'(1);
         end
         if (word_load) begin
            tdata_reg  <= word_next;
            tvalid_reg <= 1'b1;
            tuser_reg  <= in_user;
            tlast_reg  <= in_last;
         end else if (m_tready) begin
            tvalid_reg <= 1'b0;
            tuser_reg  <= 1'b0;
            tlast_reg  <= 1'b0;
         end
      end
   end

   assign m_tdata  = tdata_reg;
   assign m_tvalid = tvalid_reg;
   assign m_tuser  = tuser_reg;
   assign m_tlast  = tlast_reg;

endmodule

// File: rtl/mipi_packet_extractor.sv
// CSI-2 packet parser: decodes headers, filters VC/DT, forwards pixel lines
// to the packer and flags frame sequencing, line-length and line-count errors.
module mipi_packet_extractor
   import mipi_pkg::*;
#(
   parameter int          OUT_BYTES = 2,
   parameter int          COL_NUM   = 1280,
   parameter int          ROW_NUM   = 800,
   parameter logic [1:0]  VC        = 2'd0,
   parameter logic [5:0]  PIXEL_DT  = DT_RAW8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [7:0]             s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [8*OUT_BYTES-1:0] m_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic                   m_tuser,
   output logic                   m_tlast,
   output logic                   frame_start,
   output logic                   frame_done,
   output logic                   err_wc,
   output logic                   err_lines,
   output logic                   err_seq,
   output logic [15:0]            frame_count
);

   localparam int LINE_W = $clog2(ROW_NUM + 1);
   localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(ROW_NUM);
   localparam logic [15:0]       WC_LINE  = 16'(COL_NUM);
   localparam logic [15:0]       CRC_LEN  = 16'(CRC_BYTES);
   localparam logic [1:0]        HDR_LAST = 2'(HDR_BYTES - 1);

   parse_state_t      state_reg;
   logic [1:0]        hdr_cnt_reg;
   logic [7:0]        di_reg;
   logic [7:0]        wc_lo_reg;
   logic [7:0]        wc_hi_reg;
   logic [15:0]       byte_cnt_reg;
   logic [LINE_W-1:0] line_cnt_reg;
   logic              in_frame_reg;
   logic              tuser_arm_reg;
   logic [15:0]       frame_count_reg;
   logic              frame_start_reg;
   logic              frame_done_reg;
   logic              err_wc_reg;
   logic              err_lines_reg;
   logic              err_seq_reg;

   logic        pack_ready;
   logic        word_load;
   logic        s_fire;
   logic        pix_fire;
   logic        last_byte;
   logic [15:0] hdr_wc;
   logic [5:0]  hdr_dt;
   logic [1:0]  hdr_vc;
   logic        hdr_ours;

   assign s_ready   = (state_reg == ST_PAYLOAD) ? pack_ready : 1'b1;
   assign s_fire    = s_valid && s_ready;
   assign pix_fire  = s_fire && (state_reg == ST_PAYLOAD);
   assign last_byte = (byte_cnt_reg == 16'd1);
   assign hdr_wc    = {wc_hi_reg, wc_lo_reg};
   assign hdr_dt    = di_dt(di_reg);
   assign hdr_vc    = di_vc(di_reg);
   assign hdr_ours  = (hdr_vc == VC);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg       <= ST_HDR;
         hdr_cnt_reg     <= '0;
         di_reg          <= '0;
         wc_lo_reg       <= '0;
         wc_hi_reg       <= '0;
         byte_cnt_reg    <= '0;
         line_cnt_reg    <= '0;
         in_frame_reg    <= 1'b0;
         tuser_arm_reg   <= 1'b0;
         frame_count_reg <= '0;
         frame_start_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
         err_wc_reg      <= 1'b0;
         err_lines_reg   <= 1'b0;
         err_seq_reg     <= 1'b0;
      end else begin
         frame_start_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
         err_wc_reg      <= 1'b0;
         err_lines_reg   <= 1'b0;
         err_seq_reg     <= 1'b0;

         if (word_load) begin
            tuser_arm_reg <= 1'b0;
         end

         case (state_reg)
            ST_HDR: begin
               if (s_fire) begin
                  hdr_cnt_reg <= hdr_cnt_reg + 2'd1;
                  if (hdr_cnt_reg == 2'd0) di_reg    <= s_data;
                  if (hdr_cnt_reg == 2'd1) wc_lo_reg <= s_data;
                  if (hdr_cnt_reg == 2'd2) wc_hi_reg <= s_data;

                  // The fourth byte is the ECC; decode from the three stored bytes.
                  if (hdr_cnt_reg == HDR_LAST) begin
                     if (is_short_dt(hdr_dt)) begin
                        if (hdr_ours && hdr_dt == DT_FS) begin
                           err_seq_reg     <= in_frame_reg;
                           in_frame_reg    <= 1'b1;
                           line_cnt_reg    <= '0;
                           tuser_arm_reg   <= 1'b1;
                           frame_start_reg <= 1'b1;
                        end else if (hdr_ours && hdr_dt == DT_FE) begin
                           if (in_frame_reg) begin
                              in_frame_reg    <= 1'b0;
                              frame_done_reg  <= 1'b1;
                              frame_count_reg <= frame_count_reg + 16'd1;
                              err_lines_reg   <= (line_cnt_reg != LINE_MAX);
                           end else begin
                              err_seq_reg <= 1'b1;
                           end
                        end
                     end else begin
                        // Long packet: default is to discard it; only a clean pixel line is forwarded.
                        state_reg    <= (hdr_wc == 16'd0) ? ST_CRC : ST_SKIP;
                        byte_cnt_reg <= (hdr_wc == 16'd0) ? CRC_LEN : hdr_wc;
                        if (hdr_ours && hdr_dt == PIXEL_DT) begin
                           if (!in_frame_reg) begin
                              err_seq_reg <= 1'b1;
                           end else if (hdr_wc != WC_LINE) begin
                              err_wc_reg <= 1'b1;
                           end else if (line_cnt_reg == LINE_MAX) begin
                              err_lines_reg <= 1'b1;
                           end else begin
                              state_reg    <= ST_PAYLOAD;
                              line_cnt_reg <= line_cnt_reg + LINE_W'(1);
                           end
                        end
                     end
                  end
               end
            end

            ST_PAYLOAD, ST_SKIP: begin
               if (s_fire) begin
                  if (last_byte) begin
                     state_reg    <= ST_CRC;
                     byte_cnt_reg <= CRC_LEN;
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg - 16'd1;
                  end
               end
            end

            ST_CRC: begin
               if (s_fire) begin
                  if (last_byte) begin
                     state_reg <= ST_HDR;
                  end else begin
                     byte_cnt_reg <= byte_cnt_reg - 16'd1;
                  end
               end
            end

            default: state_reg <= ST_HDR;
         endcase
      end
   end

   mipi_byte_packer #(
      .OUT_BYTES (OUT_BYTES)
   ) u_packer (
      .clk       (clk),
      .resetn    (resetn),
      .in_data   (s_data),
      .in_valid  (pix_fire),
      .in_user   (tuser_arm_reg),
      .in_last   (last_byte),
      .in_ready  (pack_ready),
      .word_load (word_load),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tuser   (m_tuser),
      .m_tlast   (m_tlast)
   );

   assign frame_start = frame_start_reg;
   assign frame_done  = frame_done_reg;
   assign err_wc      = err_wc_reg;
   assign err_lines   = err_lines_reg;
   assign err_seq     = err_seq_reg;
   assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_mipi_packet_extractor.sv
// Packet-level reference model drives directed and random CSI-2 streams and
// checks every output beat and every header-triggered pulse.
module tb_mipi_packet_extractor;

   localparam int OB   = 2;
   localparam int COLS = 8;
   localparam int ROWS = 2;
   localparam int WPL  = COLS / OB;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [7:0]    s_data = 8'h00;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [8*OB-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tuser;
   logic          m_tlast;
   logic          frame_start;
   logic          frame_done;
   logic          err_wc;
   logic          err_lines;
   logic          err_seq;
   logic [15:0]   frame_count;

   always #5 clk = ~clk;

   mipi_packet_extractor #(
      .OUT_BYTES (OB),
      .COL_NUM   (COLS),
      .ROW_NUM   (ROWS),
      .VC        (2'd0),
      .PIXEL_DT  (6'h2A)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tuser     (m_tuser),
      .m_tlast     (m_tlast),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .err_wc      (err_wc),
      .err_lines   (err_lines),
      .err_seq     (err_seq),
      .frame_count (frame_count)
   );

   typedef struct {
      logic [8*OB-1:0] data;
      logic            user;
      logic            last;
   } beat_t;

   int    total = 0;
   int    bad   = 0;
   beat_t exp_q[$];
   beat_t got_q[$];
   beat_t ref_q[$];
   bit    md_in_frame = 0;
   bit    md_arm = 0;
   int    md_lines = 0;
   int    md_fcount = 0;
   int    n_exp[5];
   int    n_got[5];
   int    rdy_mode = 0;
   bit    gaps = 0;
   bit    fwd_byte = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Downstream readiness pattern.
   initial begin
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Per-cycle compare of output beats and pulse census.
   initial begin
      beat_t b;
      beat_t e;
      logic [4:0] p;
      forever begin
         @(negedge clk);
         #3;
         if (resetn) begin
            if (m_tvalid && m_tready) begin
               b.data = m_tdata;
               b.user = m_tuser;
               b.last = m_tlast;
               got_q.push_back(b);
               $display("beat data=0x%04h user=%0b last=%0b", m_tdata, m_tuser, m_tlast);
               if (exp_q.size() == 0) begin
                  check("beat_unexpected", 32'(m_tdata), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_data", 32'(m_tdata), 32'(e.data));
                  check("beat_user", 32'(m_tuser), 32'(e.user));
                  check("beat_last", 32'(m_tlast), 32'(e.last));
               end
            end
            if (fwd_byte && m_tvalid && !m_tready) begin
               check("s_ready_stall", 32'(s_ready), 32'd0);
            end
            p = {frame_start, frame_done, err_wc, err_lines, err_seq};
            for (int k = 0; k < 5; k++) begin
               if (p[k]) n_got[k]++;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      bad++;
      total++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Packet-level reference: p = {frame_start, frame_done, err_wc, err_lines, err_seq}.
   task automatic model(input logic [1:0] vc, input logic [5:0] dt, input int wc,
                        input logic [7:0] pl[$], output logic [4:0] p, output bit fwd);
      beat_t b;
      p   = '0;
      fwd = 0;
      if (dt < 6'h10) begin
         if (vc == 2'd0 && dt == 6'h00) begin
            p[4] = 1'b1;
            p[0] = md_in_frame;
            md_in_frame = 1;
            md_lines = 0;
            md_arm = 1;
         end else if (vc == 2'd0 && dt == 6'h01) begin
            if (md_in_frame) begin
               md_in_frame = 0;
               p[3] = 1'b1;
               md_fcount = (md_fcount + 1) % 65536;
               p[1] = (md_lines != ROWS);
            end else begin
               p[0] = 1'b1;
            end
         end
      end else if (vc == 2'd0 && dt == 6'h2A) begin
         if (!md_in_frame) p[0] = 1'b1;
         else if (wc != COLS) p[2] = 1'b1;
         else if (md_lines == ROWS) p[1] = 1'b1;
         else begin
            md_lines++;
            fwd = 1;
            for (int w = 0; w < WPL; w++) begin
               for (int k = 0; k < OB; k++) b.data[8*k +: 8] = pl[w*OB + k];
               b.user = md_arm && (w == 0);
               b.last = (w == WPL - 1);
               exp_q.push_back(b);
            end
            md_arm = 0;
         end
      end
      for (int k = 0; k < 5; k++) begin
         if (p[k]) n_exp[k]++;
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      int guard;
      while (gaps && $urandom_range(0, 3) == 0) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_data  = v;
      s_valid = 1'b1;
      guard   = 0;
      forever begin
         #2;
         if (s_ready) break;
         @(negedge clk);
         guard++;
         if (guard > 1000) begin
            $display("FAIL s_ready_timeout: got 0 expected 1 within 1000 cycles");
            bad++;
            total++;
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "stuck");
         end
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // cut < 0 sends the whole packet; otherwise stop after 'cut' payload bytes.
   task automatic send_packet(input logic [1:0] vc, input logic [5:0] dt, input int wc,
                              input bit ramp, input int cut);
      logic [7:0] pl[$];
      logic [4:0] ep;
      bit         fwd;
      logic [15:0] wcf;
      wcf = 16'(wc);
      if (dt >= 6'h10) begin
         for (int i = 0; i < wc; i++) pl.push_back(ramp ? 8'(i) : 8'($urandom));
      end
      model(vc, dt, wc, pl, ep, fwd);
      $display("pkt vc=%0d dt=0x%02h wc=%0d pulses=%05b fwd=%0b", vc, dt, wc, ep, fwd);
      send_byte({vc, dt});
      send_byte(wcf[7:0]);
      send_byte(wcf[15:8]);
      send_byte(8'($urandom));
      #1;
      check("pulses", 32'({frame_start, frame_done, err_wc, err_lines, err_seq}), 32'(ep));
      if (ep[3]) check("frame_count", 32'(frame_count), 32'(md_fcount));
      if (dt >= 6'h10) begin
         for (int i = 0; i < wc; i++) begin
            if (cut >= 0 && i >= cut) return;
            fwd_byte = fwd;
            send_byte(pl[i]);
            fwd_byte = 0;
         end
         if (cut < 0) begin
            send_byte(8'($urandom));
            send_byte(8'($urandom));
         end
      end
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic good_frame(input int lines);
      send_packet(2'd0, 6'h00, 16'h0001, 1, -1);
      for (int l = 0; l < lines; l++) send_packet(2'd0, 6'h2A, COLS, 1, -1);
      send_packet(2'd0, 6'h01, 16'h0001, 1, -1);
   endtask

   initial begin
      int r;
      repeat (3) @(negedge clk);
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_tdata", 32'(m_tdata), 32'd0);
      check("rst_tuser_tlast", 32'({m_tuser, m_tlast}), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_pulses", 32'({frame_start, frame_done, err_wc, err_lines, err_seq}), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Clean frame, no backpressure; literal expectations pin the model.
      got_q.delete();
      good_frame(2);
      wait_drain();
      check("t1_beats", 32'(got_q.size()), 32'd8);
      if (got_q.size() == 8) begin
         check("t1_beat0_data", 32'(got_q[0].data), 32'h0100);
         check("t1_beat0_user", 32'(got_q[0].user), 32'd1);
         check("t1_beat1_data", 32'(got_q[1].data), 32'h0302);
         check("t1_beat3_last", 32'(got_q[3].last), 32'd1);
         check("t1_beat2_last", 32'(got_q[2].last), 32'd0);
         check("t1_beat4_user", 32'(got_q[4].user), 32'd0);
         check("t1_beat7_last", 32'(got_q[7].last), 32'd1);
      end
      check("t1_frame_count", 32'(frame_count), 32'd1);
      ref_q = got_q;

      // Same stream with output stalled every other cycle.
      rdy_mode = 1;
      got_q.delete();
      good_frame(2);
      wait_drain();
      check("t2_beats", 32'(got_q.size()), 32'(ref_q.size()));
      for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
         check("t2_same_beat", 32'({got_q[i].data, got_q[i].user, got_q[i].last}),
               32'({ref_q[i].data, ref_q[i].user, ref_q[i].last}));
      end
      rdy_mode = 0;

      // Short line, then two good lines.
      send_packet(2'd0, 6'h00, 16'h0002, 1, -1);
      send_packet(2'd0, 6'h2A, 6, 1, -1);
      send_packet(2'd0, 6'h2A, COLS, 1, -1);
      send_packet(2'd0, 6'h2A, COLS, 1, -1);
      send_packet(2'd0, 6'h01, 16'h0002, 1, -1);

      // Too few lines, then too many lines.
      good_frame(1);
      good_frame(3);

      // Out-of-frame traffic: embedded, other VC, stray pixel line, stray FE, double FS.
      send_packet(2'd0, 6'h12, 4, 0, -1);
      send_packet(2'd1, 6'h2A, COLS, 0, -1);
      send_packet(2'd0, 6'h2A, COLS, 0, -1);
      send_packet(2'd0, 6'h01, 16'h0000, 0, -1);
      send_packet(2'd0, 6'h00, 16'h0003, 0, -1);
      good_frame(2);
      wait_drain();
      check("t6_frame_count", 32'(frame_count), 32'(md_fcount));

      // Asynchronous reset in the middle of a payload.
      send_packet(2'd0, 6'h00, 16'h0004, 1, -1);
      send_packet(2'd0, 6'h2A, COLS, 1, 3);
      fwd_byte = 0;
      #1;
      resetn = 1'b0;
      #1;
      check("arst_tvalid", 32'(m_tvalid), 32'd0);
      check("arst_tdata", 32'(m_tdata), 32'd0);
      check("arst_s_ready", 32'(s_ready), 32'd1);
      check("arst_frame_count", 32'(frame_count), 32'd0);
      exp_q.delete();
      md_in_frame = 0;
      md_arm = 0;
      md_lines = 0;
      md_fcount = 0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      got_q.delete();
      good_frame(2);
      wait_drain();
      check("arst_frame_beats", 32'(got_q.size()), 32'(2 * WPL));
      check("arst_frame_count_after", 32'(frame_count), 32'd1);

      // Randomised traffic with gaps and random backpressure.
      gaps = 1;
      rdy_mode = 2;
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0:       send_packet(2'd0, 6'h00, int'($urandom_range(0, 65535)), 0, -1);
            1:       send_packet(2'd0, 6'h01, int'($urandom_range(0, 65535)), 0, -1);
            2, 3, 4: send_packet(2'd0, 6'h2A, COLS, 0, -1);
            5:       send_packet(2'd0, 6'h2A, int'($urandom_range(0, 12)), 0, -1);
            6:       send_packet(2'($urandom_range(0, 3)), 6'h2A, COLS, 0, -1);
            7:       send_packet(2'd0, 6'h12, int'($urandom_range(0, 6)), 0, -1);
            8:       send_packet(2'd0, 6'($urandom_range(2, 3)), 0, 0, -1);
            default: send_packet(2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)),
                                 int'($urandom_range(0, 65535)), 0, -1);
         endcase
      end
      rdy_mode = 0;
      wait_drain();
      for (int k = 0; k < 5; k++) check("pulse_total", 32'(n_got[k]), 32'(n_exp[k]));
      check("final_frame_count", 32'(frame_count), 32'(md_fcount));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
